// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: lutram tag/data arrays, single-line refill, flush sweep.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_lutram #(
    parameter int W  = 32,
    parameter int D  = 128,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [D];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

module icache_ctrl #(
    parameter int LINE_W = 128,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 32,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int TAG_W = ADDR_W - IDX_W - 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data,
    input  logic              flush,
    output logic              busy,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);
    typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_MISS_REQ, S_MISS_WAIT, S_RESP} state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  flush_idx;
    logic              flush_pend;
    logic [ADDR_W-1:2] miss_addr;
    logic [31:0]       word_q;

    logic [IDX_W-1:0]  req_idx, miss_idx, tag_waddr;
    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic [TAG_W:0]    tag_rd, tag_wdata;
    logic [LINE_W-1:0] data_rd;
    logic              hit, accept, tag_we, data_we, refill;
    logic              unused_addr_lsb;

    assign req_idx  = req_addr[IDX_W+3:4];
    assign req_tag  = req_addr[ADDR_W-1:IDX_W+4];
    assign miss_idx = miss_addr[IDX_W+3:4];
    assign miss_tag = miss_addr[ADDR_W-1:IDX_W+4];
    assign unused_addr_lsb = ^req_addr[1:0];

    function automatic logic [31:0] pick(input logic [LINE_W-1:0] line, input logic [1:0] sel);
        logic [LINE_W-1:0] sh;
        sh = line >> {sel, 5'd0};
        return sh[31:0];
    endfunction

    icache_lutram #(.W(TAG_W+1), .D(DEPTH)) u_tag (
        .clk(clk), .we(tag_we), .waddr(tag_waddr), .wdata(tag_wdata),
        .raddr(req_idx), .rdata(tag_rd)
    );

    icache_lutram #(.W(LINE_W), .D(DEPTH)) u_data (
        .clk(clk), .we(data_we), .waddr(miss_idx), .wdata(mem_resp_data),
        .raddr(req_idx), .rdata(data_rd)
    );

    assign hit    = tag_rd[TAG_W] && (tag_rd[TAG_W-1:0] == req_tag);
    assign accept = req_valid && req_ready;
    assign refill = (state == S_MISS_WAIT) && mem_resp_valid;

    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_req_valid = 1'b0;
        busy          = (state != S_IDLE);
        tag_we        = 1'b0;
        tag_waddr     = miss_idx;
        tag_wdata     = {1'b1, miss_tag};
        data_we       = 1'b0;
        case (state)
            S_FLUSH: begin
                tag_we    = 1'b1;
                tag_waddr = flush_idx;
                tag_wdata = '0;
                if (flush_idx == IDX_W'(DEPTH-1)) state_nx = S_IDLE;
            end
            S_IDLE: begin
                req_ready = !flush;
                if (flush)          state_nx = S_FLUSH;
                else if (req_valid) state_nx = hit ? S_RESP : S_MISS_REQ;
            end
            S_MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nx = S_MISS_WAIT;
            end
            S_MISS_WAIT: begin
                if (mem_resp_valid) begin
                    tag_we   = 1'b1;
                    data_we  = 1'b1;
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nx   = (flush_pend || flush) ? S_FLUSH : S_IDLE;
            end
            default: state_nx = S_FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FLUSH;
            flush_idx  <= '0;
            flush_pend <= 1'b0;
            miss_addr  <= '0;
            word_q     <= '0;
        end else begin
            state     <= state_nx;
            flush_idx <= (state == S_FLUSH) ? flush_idx + 1'b1 : '0;
            // a flush seen mid-miss waits until the response has gone out
            if (state == S_RESP)
                flush_pend <= 1'b0;
            else if (flush && (state == S_MISS_REQ || state == S_MISS_WAIT))
                flush_pend <= 1'b1;
            if (accept && !hit) miss_addr <= req_addr[ADDR_W-1:2];
            if (accept && hit)  word_q    <= pick(data_rd, req_addr[3:2]);
            if (refill)         word_q    <= pick(mem_resp_data, miss_addr[3:2]);
        end
    end

    assign resp_data    = word_q;
    assign mem_req_addr = {miss_addr[ADDR_W-1:4], 4'b0};

`ifdef ICACHE_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (accept && hit)  hits_q   <= hits_q + 32'd1;
            if (accept && !hit) misses_q <= misses_q + 32'd1;
        end
    end

    assign hit_cnt  = hits_q;
    assign miss_cnt = misses_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed table, multi-cycle corner sequences, random reads vs set model.
module tb_icache_ctrl;
    localparam int DEPTH = 128;

    logic         clk = 1'b0;
    logic         rst, req_valid, req_ready, resp_valid, mem_req_valid, mem_req_ready;
    logic         mem_resp_valid, flush, busy;
    logic [31:0]  req_addr, resp_data, mem_req_addr, hit_cnt, miss_cnt;
    logic [127:0] mem_resp_data;

    int nvec = 0, nerr = 0;
    int exp_hits = 0, exp_misses = 0;

    // reference model: which line address lives in each set
    logic [27:0] set_line [DEPTH];
    bit          set_vld  [DEPTH];

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        logic [31:0] data;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .flush(flush), .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [27:0] ln, input int w);
        if (ln == 28'h100 && w == 1) return 32'hDEADBEEF;
        return ({4'h0, ln} * 32'h0001_0003) ^ (32'h1111_1111 * (w + 1));
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] ln);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_word(ln, w);
        return l;
    endfunction

    function automatic logic [31:0] stat_exp(input int n);
`ifdef ICACHE_STATS_EN
        return n;
`else
        return (n == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return set_vld[a[10:4]] && set_line[a[10:4]] == a[31:4];
    endfunction

    task automatic model_access(input logic [31:0] a);
        if (model_hit(a)) exp_hits++;
        else begin
            exp_misses++;
            set_vld[a[10:4]]  = 1'b1;
            set_line[a[10:4]] = a[31:4];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) set_vld[i] = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_flush(input string nm);
        int n = 0;
        while (busy && n < 1000) begin
            n++;
            tick();
        end
        chk(nm, n, DEPTH);
        chk({nm, "_ready"}, req_ready, 1);
        model_clear();
    endtask

    task automatic do_read(input logic [31:0] a, input int req_lat, input int resp_lat, input bit fw,
                           output bit miss, output logic [31:0] data);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        while (!req_ready && n < 400) begin
            tick();
            n++;
        end
        chk("req_ready_wait", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;
        miss = mem_req_valid;
        if (miss) begin
            chk("mem_req_addr", mem_req_addr, {a[31:4], 4'h0});
            chk("resp_early", resp_valid, 0);
            for (int i = 0; i < req_lat; i++) begin
                mem_resp_valid = 1'b1;    // stray response while request unacknowledged
                mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
                tick();
                chk("mem_req_hold", mem_req_valid, 1);
                chk("mem_req_addr_hold", mem_req_addr, {a[31:4], 4'h0});
            end
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            chk("mem_req_drop", mem_req_valid, 0);
            flush = fw;
            for (int i = 0; i < resp_lat; i++) begin
                tick();
                flush = 1'b0;
                chk("resp_wait", resp_valid, 0);
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = line_of(a[31:4]);
            tick();
            mem_resp_valid = 1'b0;
            mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            flush = 1'b0;
        end
        chk("resp_valid", resp_valid, 1);
        data = resp_data;
        tick();
        chk("resp_pulse", resp_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          m;
        logic [31:0] d, a;

        tbl[0] = '{32'h0000_1004, 1'b1, 32'hDEADBEEF};
        tbl[1] = '{32'h0000_1008, 1'b0, mem_word(28'h100, 2)};
        tbl[2] = '{32'h0000_1804, 1'b1, mem_word(28'h180, 1)};
        tbl[3] = '{32'h0000_1004, 1'b1, 32'hDEADBEEF};
        tbl[4] = '{32'h0000_1000, 1'b0, mem_word(28'h100, 0)};
        tbl[5] = '{32'h0000_100C, 1'b0, mem_word(28'h100, 3)};
        tbl[6] = '{32'h0000_0000, 1'b1, mem_word(28'h000, 0)};
        tbl[7] = '{32'h0000_07F0, 1'b1, mem_word(28'h07F, 0)};
        tbl[8] = '{32'hFFFF_FFFC, 1'b1, mem_word(28'hFFFFFFF, 3)};
        tbl[9] = '{32'h0000_07F4, 1'b1, mem_word(28'h07F, 1)};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        model_clear();
        tick();
        tick();
        chk("rst_busy", busy, 1);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        wait_flush("reset_flush_len");

        for (int i = 0; i < 10; i++) begin
            do_read(tbl[i].addr, i % 3, (i + 1) % 3, 1'b0, m, d);
            chk($sformatf("tbl%0d_miss", i), m, tbl[i].miss);
            chk($sformatf("tbl%0d_data", i), d, tbl[i].data);
            model_access(tbl[i].addr);
            if (i == 1) begin
                chk("cnt_hit_after_reread", hit_cnt, stat_exp(exp_hits));
                chk("cnt_miss_after_reread", miss_cnt, stat_exp(exp_misses));
            end
        end

        // flush and request together in IDLE: flush wins
        req_valid = 1'b1; req_addr = 32'h0000_1004; flush = 1'b1;
        #1;
        chk("flush_vs_req_ready", req_ready, 0);
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_vs_req_mem", mem_req_valid, 0);
        chk("flush_vs_req_busy", busy, 1);
        wait_flush("flush_idle_len");
        do_read(32'h0000_1004, 0, 1, 1'b0, m, d);
        chk("post_flush_miss", m, 1);
        chk("post_flush_data", d, 32'hDEADBEEF);
        model_access(32'h0000_1004);

        // flush during MISS_WAIT: response first, then full sweep
        do_read(32'h0000_1804, 1, 2, 1'b1, m, d);
        chk("pend_flush_miss", m, 1);
        chk("pend_flush_data", d, mem_word(28'h180, 1));
        model_access(32'h0000_1804);
        chk("pend_flush_busy", busy, 1);
        wait_flush("pend_flush_len");
        do_read(32'h0000_1004, 0, 0, 1'b0, m, d);
        chk("after_pend_miss", m, 1);
        chk("after_pend_data", d, 32'hDEADBEEF);
        model_access(32'h0000_1004);

        // reset during MISS_WAIT abandons the miss
        req_valid = 1'b1; req_addr = 32'h0000_2000;
        tick();
        req_valid = 1'b0;
        chk("rmid_mem_req", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = line_of(28'h200);
        tick();
        rst = 1'b0; mem_resp_valid = 1'b0;
        chk("rmid_no_resp", resp_valid, 0);
        chk("rmid_busy", busy, 1);
        chk("rmid_hit_cnt", hit_cnt, 0);
        chk("rmid_miss_cnt", miss_cnt, 0);
        exp_hits = 0; exp_misses = 0;
        wait_flush("rmid_flush_len");
        do_read(32'h0000_2000, 0, 0, 1'b0, m, d);
        chk("rmid_reread_miss", m, 1);
        chk("rmid_reread_data", d, mem_word(28'h200, 0));
        model_access(32'h0000_2000);

        // random reads over a small address pool so sets see hits and conflicts
        for (int i = 0; i < 200; i++) begin
            bit exp_m, fw;
            a = ($urandom_range(0, 3) << 11) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
            exp_m = !model_hit(a);
            fw = ($urandom_range(0, 19) == 0);
            do_read(a, $urandom_range(0, 2), $urandom_range(0, 3), fw, m, d);
            chk("rand_miss", m, exp_m);
            chk("rand_data", d, mem_word(a[31:4], a[3:2]));
            model_access(a);
            if (fw && m) wait_flush("rand_pend_flush_len");
            else if ($urandom_range(0, 39) == 0) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                wait_flush("rand_flush_len");
            end
        end

        chk("final_hit_cnt", hit_cnt, stat_exp(exp_hits));
        chk("final_miss_cnt", miss_cnt, stat_exp(exp_misses));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
